// File: rtl/alu_issue.sv
// Execute-stage sequencer for the 8-bit ALU. It takes one instruction at a time,
// reads both operands from an 8 x 8-bit register file and drives them to the ALU.
// It captures the ALU result, then writes back the accumulator and both flags.
module alu_issue #(
  parameter int unsigned NREG = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [15:0] in_instr,
  output logic       in_ready,
  input  logic       ld_en,
  input  logic [2:0] ld_addr,
  input  logic [7:0] ld_data,
  input  logic [2:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic [3:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_acc,
  input  logic       alu_flag,
  input  logic       alu_eq,
  output logic       flag,
  output logic       eq,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

  state_e     state;
  logic [3:0] ir_op;
  logic [2:0] ir_rd;
  logic [2:0] ir_rs;
  logic [7:0] res_acc;
  logic       res_flag;
  logic       res_eq;
  logic [7:0] regs [NREG];
  logic       defined_op;
  logic       unused_instr;

  // Instruction bits outside the opcode/rd/rs fields carry no meaning here.
  assign unused_instr = ^{in_instr[11], in_instr[7], in_instr[3:0]};

  assign defined_op = (ir_op <= 4'hA);
  assign dbg_data   = regs[dbg_addr];

  // Sequencer FSM with its registered handshake, ALU-port and flag outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      ir_op      <= 4'h0;
      ir_rd      <= 3'd0;
      ir_rs      <= 3'd0;
      alu_opcode <= 4'h0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      res_acc    <= 8'h00;
      res_flag   <= 1'b0;
      res_eq     <= 1'b0;
      flag       <= 1'b0;
      eq         <= 1'b0;
      done       <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            ir_op    <= in_instr[15:12];
            ir_rd    <= in_instr[10:8];
            ir_rs    <= in_instr[6:4];
            in_ready <= 1'b0;
            state    <= StRead;
          end
        end
        StRead: begin
          // Any load made on the accept edge is already visible in regs here.
          alu_a      <= regs[ir_rd];
          alu_b      <= regs[ir_rs];
          alu_opcode <= ir_op;
          state      <= StExec;
        end
        StExec: begin
          res_acc  <= alu_acc;
          res_flag <= alu_flag;
          res_eq   <= alu_eq;
          done     <= 1'b1;
          state    <= StWb;
        end
        StWb: begin
          if (defined_op) begin
            flag <= res_flag;
            eq   <= res_eq;
          end
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Register file: external loads only while idle, ALU writeback at the end of WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i[2:0]] <= 8'h00;
      end
    end else if (state == StIdle && ld_en) begin
      regs[ld_addr] <= ld_data;
    end else if (state == StWb && defined_op && ir_op != 4'h4) begin
      regs[ir_rd] <= res_acc;
    end
  end

endmodule
